// File: rtl/boot_loader_if.sv
// Byte-stream ingress and instruction-memory write/status bundle of the boot loader.
// The slave side is the loader; the master side is the stream source and the core.
interface boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
    );
endinterface

// File: rtl/boot_loader.sv
// Loads a counted, XOR-checksummed byte stream into instruction memory word by word
// and holds the core in reset until the whole image has been verified.
module boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.slave  bus
);
    localparam logic [2:0] S_CNT_HI = 3'd0;
    localparam logic [2:0] S_CNT_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CHK    = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        xor_q, xor_d;
    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept_s;
    logic [15:0]       cnt_full_s;
    logic [ADDR_W:0]   word_nxt_s;
    logic [31:0]       word_nxt_ext_s;

    assign accept_s       = bus.rx_valid & rx_ready_q;
    assign cnt_full_s     = {cnt_q[15:8], bus.rx_data};
    assign word_nxt_s     = word_idx_q + {{ADDR_W{1'b0}}, 1'b1};
    assign word_nxt_ext_s = {{(31 - ADDR_W){1'b0}}, word_nxt_s};

    // Next-state logic for the load FSM, counters, checksum and registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        xor_d        = xor_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            S_CNT_HI: begin
                if (accept_s) begin
                    cnt_d   = {bus.rx_data, cnt_q[7:0]};
                    xor_d   = xor_fold(xor_q, bus.rx_data);
                    state_d = S_CNT_LO;
                end else begin
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_LO: begin
                if (accept_s) begin
                    cnt_d = cnt_full_s;
                    xor_d = xor_fold(xor_q, bus.rx_data);
                    if ({16'd0, cnt_full_s} > DEPTH) begin
                        state_d = S_ERR;
                    end else if (cnt_full_s == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d    = S_DATA;
                        word_idx_d = '0;
                        byte_idx_d = 2'd0;
                    end
                end else begin
                    state_d = S_CNT_LO;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    xor_d      = xor_fold(xor_q, bus.rx_data);
                    asm_d      = {asm_q[15:0], bus.rx_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_idx_q[ADDR_W-1:0];
                        imem_wdata_d = {asm_q, bus.rx_data};
                        word_idx_d   = word_nxt_s;
                        byte_idx_d   = 2'd0;
                        if (word_nxt_ext_s == {16'd0, cnt_q}) begin
                            state_d = S_CHK;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHK: begin
                if (accept_s) begin
                    if (bus.rx_data == xor_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = S_CHK;
                end
            end
            S_RUN:   state_d = S_RUN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        rx_ready_d = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) ||
                     (state_d == S_DATA)   || (state_d == S_CHK);
        core_rst_d = (state_d != S_RUN);
        done_d     = (state_d == S_RUN);
        err_d      = (state_d == S_ERR);
    end

    // State and output registers; core_rst is forced high asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_CNT_HI;
            cnt_q        <= 16'd0;
            word_idx_q   <= '0;
            byte_idx_q   <= 2'd0;
            asm_q        <= 24'd0;
            xor_q        <= 8'd0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            xor_q        <= xor_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed vector table, timing sequences,
// and randomized streams checked against a stream-parsing reference model.
module tb_boot_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    boot_loader_if #(.ADDR_W(ADDR_W)) bus ();
    boot_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Write monitor: logs every strobe and flags strobes on consecutive cycles.
    int          wr_cnt = 0;
    logic [7:0]  wr_addr_a [0:299];
    logic [31:0] wr_data_a [0:299];
    bit          dbl_we = 1'b0;
    logic        prev_we = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            wr_cnt  <= 0;
            dbl_we  <= 1'b0;
            prev_we <= 1'b0;
        end else begin
            prev_we <= bus.imem_we;
            if (bus.imem_we && prev_we) dbl_we <= 1'b1;
            if (bus.imem_we) begin
                if (wr_cnt < 300) begin
                    wr_addr_a[wr_cnt] <= bus.imem_addr;
                    wr_data_a[wr_cnt] <= bus.imem_wdata;
                end
                wr_cnt <= wr_cnt + 1;
            end
        end
    end

    logic [7:0]  stim_q [$];
    logic [31:0] exp_w_q [$];
    bit          exp_done, exp_err;

    typedef struct packed {
        logic [7:0]            len;
        logic [0:15][7:0]      b;
        logic                  gap;
        logic                  done;
        logic                  err;
        logic [7:0]            nwr;
        logic [0:3][31:0]      w;
    } vec_t;
    vec_t tbl [0:4];

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            int g;
            g = $urandom_range(0, 3);
            bus.rx_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (!bus.rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) begin
            n_total++;
            $display("FAIL send_timeout: rx_ready stayed 0 for byte %0h", b);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_stream(input bit gap);
        do_reset();
        foreach (stim_q[i]) send_byte(stim_q[i], gap);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_done"}, {31'd0, bus.done}, {31'd0, exp_done});
        check({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
        check({tag, "_core_rst"}, {31'd0, bus.core_rst}, {31'd0, !exp_done});
        check({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
        check({tag, "_nwr"}, wr_cnt, exp_w_q.size());
        check({tag, "_we_pulse"}, {31'd0, dbl_we}, 32'd0);
        for (int i = 0; i < exp_w_q.size() && i < wr_cnt && i < 300; i++) begin
            check($sformatf("%s_addr%0d", tag, i), {24'd0, wr_addr_a[i]}, i);
            check($sformatf("%s_data%0d", tag, i), wr_data_a[i], exp_w_q[i]);
        end
    endtask

    // Reference model: parse the byte stream directly into expected words and outcome.
    task automatic model();
        int n;
        logic [7:0] x;
        n = int'({stim_q[0], stim_q[1]});
        exp_w_q.delete();
        if (n > DEPTH) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
        end else begin
            for (int k = 0; k < n; k++)
                exp_w_q.push_back({stim_q[2+4*k], stim_q[3+4*k], stim_q[4+4*k], stim_q[5+4*k]});
            x = 8'h00;
            for (int i = 0; i < 2 + 4 * n; i++) x = x ^ stim_q[i];
            exp_done = (x == stim_q[2+4*n]);
            exp_err  = !exp_done;
        end
    endtask

    task automatic gen_random(input int n, input bit bad_chk);
        logic [7:0] x, b;
        stim_q.delete();
        stim_q.push_back(n[15:8]);
        stim_q.push_back(n[7:0]);
        x = n[15:8] ^ n[7:0];
        if (n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                stim_q.push_back(b);
                x = x ^ b;
            end
            if (bad_chk) x = x ^ 8'($urandom_range(1, 255));
            stim_q.push_back(x);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{len: 8'd7, b: {8'h00, 8'h01, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h88, 72'h0},
                   gap: 1'b0, done: 1'b1, err: 1'b0, nwr: 8'd1, w: {32'h8C010004, 96'h0}};
        tbl[1] = '{len: 8'd11, b: {8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01,
                                   8'h00, 8'h00, 8'h8B, 40'h0},
                   gap: 1'b1, done: 1'b1, err: 1'b0, nwr: 8'd2,
                   w: {32'h20010005, 32'hAC010000, 64'h0}};
        tbl[2] = '{len: 8'd7, b: {8'h00, 8'h01, 8'h8C, 8'h01, 8'h00, 8'h04, 8'h89, 72'h0},
                   gap: 1'b0, done: 1'b0, err: 1'b1, nwr: 8'd1, w: {32'h8C010004, 96'h0}};
        tbl[3] = '{len: 8'd2, b: {8'h01, 8'h01, 112'h0},
                   gap: 1'b0, done: 1'b0, err: 1'b1, nwr: 8'd0, w: 128'h0};
        tbl[4] = '{len: 8'd3, b: {8'h00, 8'h00, 8'h00, 104'h0},
                   gap: 1'b1, done: 1'b1, err: 1'b0, nwr: 8'd0, w: 128'h0};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        check("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
        check("rst_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
        check("rst_imem_wdata", bus.imem_wdata, 32'd0);
        check("rst_core_rst", {31'd0, bus.core_rst}, 32'd1);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rx_ready_rise", {31'd0, bus.rx_ready}, 32'd1);

        for (int v = 0; v < 5; v++) begin
            stim_q.delete();
            exp_w_q.delete();
            for (int j = 0; j < int'(tbl[v].len); j++) stim_q.push_back(tbl[v].b[j]);
            for (int k = 0; k < int'(tbl[v].nwr); k++) exp_w_q.push_back(tbl[v].w[k]);
            exp_done = tbl[v].done;
            exp_err  = tbl[v].err;
            run_stream(tbl[v].gap);
            check_result($sformatf("vec%0d", v));
        end

        // N=1 cycle timing: write strobe and done/core_rst one cycle after accept.
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h8C, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        check("t_we_before", {31'd0, bus.imem_we}, 32'd0);
        send_byte(8'h04, 1'b0);
        check("t_we_pulse", {31'd0, bus.imem_we}, 32'd1);
        check("t_we_addr", {24'd0, bus.imem_addr}, 32'd0);
        check("t_we_data", bus.imem_wdata, 32'h8C010004);
        check("t_done_early", {31'd0, bus.done}, 32'd0);
        send_byte(8'h88, 1'b0);
        check("t_we_drop", {31'd0, bus.imem_we}, 32'd0);
        check("t_wdata_hold", bus.imem_wdata, 32'h8C010004);
        check("t_done_e1", {31'd0, bus.done}, 32'd1);
        check("t_core_rst_e1", {31'd0, bus.core_rst}, 32'd0);
        check("t_rx_ready_e1", {31'd0, bus.rx_ready}, 32'd0);

        // Bad count: err right after the second count byte, never a write.
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        check("bad_err_e1", {31'd0, bus.err}, 32'd1);
        check("bad_rx_ready_e1", {31'd0, bus.rx_ready}, 32'd0);
        repeat (4) @(negedge clk);
        check("bad_nwr", wr_cnt, 32'd0);
        check("bad_core_rst", {31'd0, bus.core_rst}, 32'd1);

        // N=0 then extra bytes are ignored.
        stim_q.delete();
        stim_q.push_back(8'h00); stim_q.push_back(8'h00); stim_q.push_back(8'h00);
        run_stream(1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("n0_ign_nwr", wr_cnt, 32'd0);
        check("n0_ign_done", {31'd0, bus.done}, 32'd1);
        check("n0_ign_err", {31'd0, bus.err}, 32'd0);

        // Reset mid-load after the second data byte, then a clean reload.
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h8C, 1'b0);
        send_byte(8'h01, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        check("mid_imem_we", {31'd0, bus.imem_we}, 32'd0);
        check("mid_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
        check("mid_imem_wdata", bus.imem_wdata, 32'd0);
        check("mid_core_rst", {31'd0, bus.core_rst}, 32'd1);
        check("mid_done", {31'd0, bus.done}, 32'd0);
        check("mid_err", {31'd0, bus.err}, 32'd0);
        stim_q.delete();
        for (int j = 0; j < 7; j++) stim_q.push_back(tbl[0].b[j]);
        model();
        run_stream(1'b0);
        check_result("mid_reload");

        // Full-capacity image: last write lands at DEPTH-1.
        gen_random(DEPTH, 1'b0);
        model();
        run_stream(1'b0);
        check_result("n256");
        check("n256_last_addr", {24'd0, wr_addr_a[DEPTH-1]}, 32'h000000FF);

        for (int r = 0; r < 16; r++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH + 1, 2000) : $urandom_range(0, 6);
            gen_random(n, $urandom_range(0, 3) == 0);
            model();
            run_stream($urandom_range(0, 1) == 1);
            check_result($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
